// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch
// Purpose  : Decimal BCD stopwatch counting synchronised tick_clk rising edges
//            in the clock_in domain. Optional lap hold is enabled by the
//            macro BCD_STOPWATCH_LAP_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                tick_clk,
  input  logic                start_stop,
  input  logic                clear,
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  input  logic                lap,
`endif
  output logic [4*DIGITS-1:0] bcd,
  output logic                running,
  output logic                overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_prev;
  logic                  r_tick_pulse;
  logic                  w_tick_rise;
  logic [4*DIGITS-1:0]   r_count;
  logic [4*DIGITS-1:0]   w_count_inc;
  logic                  w_wrap;
  logic                  w_count_en;
  logic                  r_running;
  logic                  r_overflow;

  // tick_clk is only ever sampled; its rising edge becomes a one-cycle enable
  assign w_tick_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync       <= '0;
      r_prev       <= 1'b0;
      r_tick_pulse <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], tick_clk};
      r_prev       <= r_sync[SYNC_STAGES-1];
      r_tick_pulse <= w_tick_rise;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else if (start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Ripple-carry decimal increment; carry out of the top digit means wrap
  always_comb begin
    logic v_carry;
    v_carry     = 1'b1;
    w_count_inc = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (v_carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          v_carry               = 1'b0;
        end
      end
    end
    w_wrap = v_carry;
  end

  assign w_count_en = r_tick_pulse & (r_state == ST_RUN);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
      if (clear) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_count_en) begin
        r_count <= w_count_inc;
        if (w_wrap) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  logic                r_hold;
  logic [4*DIGITS-1:0] r_snap;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= 1'b0;
      r_snap <= '0;
    end else if (clear) begin
      r_hold <= 1'b0;
    end else if (lap && (r_state != ST_IDLE)) begin
      if (!r_hold) begin
        r_hold <= 1'b1;
        r_snap <= r_count;
      end else begin
        r_hold <= 1'b0;
      end
    end
  end

  assign bcd = r_hold ? r_snap : r_count;
`else
  assign bcd = r_count;
`endif

  assign running  = r_running;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
